uart_rs232_rx: RTL and testbench



---
 rtl/uart_rs232_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rs232_rx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rs232_rx.sv
// RS-232 UART receiver: oversampled start-bit detection, 5..8 data bits LSB first, one stop bit.
// Shares the 16x-baud Tick enable with the companion transmitter.
module uart_rs232_rx #(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Tick,
    input  logic       i_RxEn,
    input  logic [3:0] i_NBits,
    input  logic       i_Rx,
    output logic [7:0] o_RxData,
    output logic       o_RxDone,
    output logic       o_FrameErr,
    output logic       o_Busy
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            r_state, w_stateNext;
    logic [SYNC_STAGES-1:0] r_sync;
    logic              w_rxs;
    logic              r_armed, w_armedNext;
    logic [CW-1:0]     r_tickCnt, w_tickCntNext;
    logic [3:0]        r_bitCnt, w_bitCntNext;
    logic [3:0]        r_nBits, w_nBitsNext;
    logic [7:0]        r_shift, w_shiftNext;
    logic [7:0]        r_rxData, w_rxDataNext;
    logic              r_done, w_doneNext;
    logic              r_frameErr, w_frameErrNext;
    logic [3:0]        w_nBitsClamped;
    logic [3:0]        w_shiftAmt;

    // Synchroniser resets to the idle-high level so reset never looks like a start edge
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_Rx};
        end
    end

    assign w_rxs          = r_sync[SYNC_STAGES-1];
    assign w_nBitsClamped = (i_NBits < 4'd5 || i_NBits > 4'd8) ? 4'd8 : i_NBits;
    assign w_shiftAmt     = 4'd8 - r_nBits;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state    <= IDLE;
            r_armed    <= 1'b0;
            r_tickCnt  <= '0;
            r_bitCnt   <= '0;
            r_nBits    <= 4'd8;
            r_shift    <= '0;
            r_rxData   <= '0;
            r_done     <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_armed    <= w_armedNext;
            r_tickCnt  <= w_tickCntNext;
            r_bitCnt   <= w_bitCntNext;
            r_nBits    <= w_nBitsNext;
            r_shift    <= w_shiftNext;
            r_rxData   <= w_rxDataNext;
            r_done     <= w_doneNext;
            r_frameErr <= w_frameErrNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_armedNext    = r_armed;
        w_tickCntNext  = r_tickCnt;
        w_bitCntNext   = r_bitCnt;
        w_nBitsNext    = r_nBits;
        w_shiftNext    = r_shift;
        w_rxDataNext   = r_rxData;
        w_doneNext     = 1'b0;
        w_frameErrNext = 1'b0;

        case (r_state)
            // A start edge is only accepted after the line has been seen high (armed),
            // so a stuck-low line or break cannot produce a stream of frames.
            IDLE: begin
                if (i_Tick && i_RxEn) begin
                    if (w_rxs) begin
                        w_armedNext = 1'b1;
                    end else if (r_armed) begin
                        w_stateNext   = START;
                        w_tickCntNext = '0;
                        w_armedNext   = 1'b0;
                    end
                end
            end
            START: begin
                if (i_Tick) begin
                    if (r_tickCnt == HALF_LAST) begin
                        if (!w_rxs) begin
                            w_stateNext   = DATA;
                            w_tickCntNext = '0;
                            w_bitCntNext  = '0;
                            w_nBitsNext   = w_nBitsClamped;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_tickCntNext = r_tickCnt + CW'(1);
                    end
                end
            end
            DATA: begin
                if (i_Tick) begin
                    if (r_tickCnt == FULL_LAST) begin
                        w_shiftNext   = {w_rxs, r_shift[7:1]};
                        w_tickCntNext = '0;
                        w_bitCntNext  = r_bitCnt + 4'd1;
                        if (r_bitCnt + 4'd1 == r_nBits) begin
                            w_stateNext = STOP;
                        end
                    end else begin
                        w_tickCntNext = r_tickCnt + CW'(1);
                    end
                end
            end
            STOP: begin
                if (i_Tick) begin
                    if (r_tickCnt == FULL_LAST) begin
                        w_rxDataNext   = r_shift >> w_shiftAmt;
                        w_doneNext     = 1'b1;
                        w_frameErrNext = ~w_rxs;
                        w_armedNext    = w_rxs;
                        w_tickCntNext  = '0;
                        w_stateNext    = IDLE;
                    end else begin
                        w_tickCntNext = r_tickCnt + CW'(1);
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign o_RxData   = r_rxData;
    assign o_RxDone   = r_done;
    assign o_FrameErr = r_frameErr;
    assign o_Busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rs232_rx.sv
// Directed self-checking bench for uart_rs232_rx: Tick every 4 clocks, 16 ticks per bit (64 clocks).
module tb_uart_rs232_rx;

    localparam int BIT_CLKS = 64;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_Tick;
    logic       i_RxEn = 1'b1;
    logic [3:0] i_NBits = 4'd8;
    logic       i_Rx = 1'b1;
    logic [7:0] o_RxData;
    logic       o_RxDone;
    logic       o_FrameErr;
    logic       o_Busy;

    int checks = 0;
    int failures = 0;

    logic [1:0] tickDiv = 2'd0;
    logic [7:0] rxQ[$];
    logic       errQ[$];
    logic       busySeen = 1'b0;
    logic       prevDone = 1'b0;
    int         longPulses = 0;
    int         errWithoutDone = 0;

    uart_rs232_rx #(.OVS(16), .SYNC_STAGES(2)) dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Tick    (i_Tick),
        .i_RxEn    (i_RxEn),
        .i_NBits   (i_NBits),
        .i_Rx      (i_Rx),
        .o_RxData  (o_RxData),
        .o_RxDone  (o_RxDone),
        .o_FrameErr(o_FrameErr),
        .o_Busy    (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) tickDiv <= tickDiv + 2'd1;
    assign i_Tick = (tickDiv == 2'd3);

    // Observe outputs on the falling edge, away from the active edge
    always @(negedge i_Clk) begin
        if (o_RxDone) begin
            rxQ.push_back(o_RxData);
            errQ.push_back(o_FrameErr);
        end
        if (o_RxDone && prevDone) longPulses++;
        if (o_FrameErr && !o_RxDone) errWithoutDone++;
        if (o_Busy) busySeen = 1'b1;
        prevDone = o_RxDone;
    end

    task automatic driveBit(input logic v, input int clks);
        i_Rx = v;
        repeat (clks) @(posedge i_Clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] data, input int nb, input logic stopBit);
        driveBit(1'b0, BIT_CLKS);
        for (int i = 0; i < nb; i++) driveBit(data[i], BIT_CLKS);
        driveBit(stopBit, BIT_CLKS);
    endtask

    task automatic test_reset();
        int n0;
        i_Rst = 1'b1;
        repeat (3) @(posedge i_Clk);
        #1;
        checks++;
        if (o_Busy !== 1'b0 || o_RxDone !== 1'b0 || o_FrameErr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b ferr=%b required 0 0 0", o_Busy, o_RxDone, o_FrameErr);
        end
        checks++;
        if (o_RxData !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h required 00", o_RxData);
        end
        i_Rst = 1'b0;
        n0 = rxQ.size();
        busySeen = 1'b0;
        repeat (1000) @(posedge i_Clk);
        #1;
        checks++;
        if (busySeen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_busy: busy seen=%b required 0", busySeen);
        end
        checks++;
        if (rxQ.size() != n0) begin
            failures++;
            $display("[TB] FAIL idle_done: frames=%0d required %0d", rxQ.size(), n0);
        end
        checks++;
        if (o_RxData !== 8'h00) begin
            failures++;
            $display("[TB] FAIL idle_data: got %h required 00", o_RxData);
        end
    endtask

    task automatic test_8bit();
        int n0 = rxQ.size();
        i_NBits = 4'd8;
        sendFrame(8'h5A, 8, 1'b1);
        driveBit(1'b1, 16);
        checks++;
        if (rxQ.size() != n0 + 1) begin
            failures++;
            $display("[TB] FAIL frame8_count: frames=%0d required %0d", rxQ.size(), n0 + 1);
        end else begin
            checks++;
            if (rxQ[n0] !== 8'h5A || errQ[n0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL frame8_data: data=%h ferr=%b required 5a 0", rxQ[n0], errQ[n0]);
            end
        end
        checks++;
        if (o_RxData !== 8'h5A || o_Busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame8_hold: data=%h busy=%b required 5a 0", o_RxData, o_Busy);
        end
    endtask

    task automatic test_nbits();
        int n0 = rxQ.size();
        i_NBits = 4'd5;
        sendFrame(8'h16, 5, 1'b1);
        driveBit(1'b1, 16);
        checks++;
        if (rxQ.size() != n0 + 1 || o_RxData !== 8'h16) begin
            failures++;
            $display("[TB] FAIL frame5: frames=%0d data=%h required %0d 16", rxQ.size(), o_RxData, n0 + 1);
        end
        i_NBits = 4'd12;
        sendFrame(8'hC3, 8, 1'b1);
        driveBit(1'b1, 16);
        checks++;
        if (rxQ.size() != n0 + 2 || o_RxData !== 8'hC3) begin
            failures++;
            $display("[TB] FAIL nbits_clamp: frames=%0d data=%h required %0d c3", rxQ.size(), o_RxData, n0 + 2);
        end
        i_NBits = 4'd8;
    endtask

    task automatic test_glitch_frame_err();
        int n0 = rxQ.size();
        driveBit(1'b0, 16);
        driveBit(1'b1, 200);
        checks++;
        if (rxQ.size() != n0 || o_Busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch: frames=%0d busy=%b required %0d 0", rxQ.size(), o_Busy, n0);
        end
        sendFrame(8'h81, 8, 1'b0);
        checks++;
        if (rxQ.size() != n0 + 1) begin
            failures++;
            $display("[TB] FAIL ferr_count: frames=%0d required %0d", rxQ.size(), n0 + 1);
        end else begin
            checks++;
            if (rxQ[n0] !== 8'h81 || errQ[n0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ferr_data: data=%h ferr=%b required 81 1", rxQ[n0], errQ[n0]);
            end
        end
        busySeen = 1'b0;
        driveBit(1'b0, 6 * BIT_CLKS);
        checks++;
        if (rxQ.size() != n0 + 1 || busySeen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stuck_low: frames=%0d busy seen=%b required %0d 0", rxQ.size(), busySeen, n0 + 1);
        end
        driveBit(1'b1, BIT_CLKS);
        sendFrame(8'h3E, 8, 1'b1);
        driveBit(1'b1, 16);
        checks++;
        if (rxQ.size() != n0 + 2 || o_RxData !== 8'h3E) begin
            failures++;
            $display("[TB] FAIL after_high: frames=%0d data=%h required %0d 3e", rxQ.size(), o_RxData, n0 + 2);
        end
    endtask

    task automatic test_back_to_back();
        int n0 = rxQ.size();
        sendFrame(8'h00, 8, 1'b1);
        sendFrame(8'hFF, 8, 1'b1);
        driveBit(1'b1, 16);
        checks++;
        if (rxQ.size() != n0 + 2) begin
            failures++;
            $display("[TB] FAIL b2b_count: frames=%0d required %0d", rxQ.size(), n0 + 2);
        end else begin
            checks++;
            if (rxQ[n0] !== 8'h00 || rxQ[n0 + 1] !== 8'hFF) begin
                failures++;
                $display("[TB] FAIL b2b_data: got %h %h required 00 ff", rxQ[n0], rxQ[n0 + 1]);
            end
        end
    endtask

    task automatic test_rxen();
        int n0 = rxQ.size();
        driveBit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) i_RxEn = 1'b0;
            driveBit(((8'h3C >> i) & 8'h01) != 8'h00, BIT_CLKS);
        end
        driveBit(1'b1, BIT_CLKS);
        driveBit(1'b1, 16);
        checks++;
        if (rxQ.size() != n0 + 1 || o_RxData !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL rxen_drop: frames=%0d data=%h required %0d 3c", rxQ.size(), o_RxData, n0 + 1);
        end
        busySeen = 1'b0;
        sendFrame(8'h55, 8, 1'b1);
        driveBit(1'b1, 16);
        checks++;
        if (rxQ.size() != n0 + 1 || busySeen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rxen_off: frames=%0d busy seen=%b required %0d 0", rxQ.size(), busySeen, n0 + 1);
        end
        i_RxEn = 1'b1;
        driveBit(1'b1, BIT_CLKS);
    endtask

    task automatic test_reset_mid_frame();
        int n0 = rxQ.size();
        driveBit(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) driveBit(((8'hA5 >> i) & 8'h01) != 8'h00, BIT_CLKS);
        driveBit(1'b0, 16);
        checks++;
        if (o_Busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset_busy: busy=%b required 1", o_Busy);
        end
        i_Rst = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Rst = 1'b0;
        checks++;
        if (o_Busy !== 1'b0 || o_RxData !== 8'h00) begin
            failures++;
            $display("[TB] FAIL mid_reset: busy=%b data=%h required 0 00", o_Busy, o_RxData);
        end
        driveBit(1'b1, 8 * BIT_CLKS);
        checks++;
        if (rxQ.size() != n0) begin
            failures++;
            $display("[TB] FAIL aborted_done: frames=%0d required %0d", rxQ.size(), n0);
        end
        sendFrame(8'hA5, 8, 1'b1);
        driveBit(1'b1, 16);
        checks++;
        if (rxQ.size() != n0 + 1 || o_RxData !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL post_reset: frames=%0d data=%h required %0d a5", rxQ.size(), o_RxData, n0 + 1);
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (longPulses != 0) begin
            failures++;
            $display("[TB] FAIL done_width: long pulses=%0d required 0", longPulses);
        end
        checks++;
        if (errWithoutDone != 0) begin
            failures++;
            $display("[TB] FAIL ferr_alone: count=%0d required 0", errWithoutDone);
        end
    endtask

    initial begin
        test_reset();
        test_8bit();
        test_nbits();
        test_glitch_frame_err();
        test_back_to_back();
        test_rxen();
        test_reset_mid_frame();
        test_pulse_shape();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
